// File: rtl/comb_wires_deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel word assembler.
package comb_wires_deser_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } deser_state_e;

    localparam int DESER_NBITS = 100;

    function automatic int deser_count_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/comb_wires_deser_shreg.sv
// NBITS-wide shift register filled one bit per enabled cycle.
// Shift direction: MSB-first by default, LSB-first when COMB_WIRES_DESER_LSB_FIRST_EN is defined.
module comb_wires_deser_shreg
    import comb_wires_deser_pkg::*;
#(
    parameter int NBITS = DESER_NBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [NBITS-1:0] data
);

    logic [NBITS-1:0] data_q;
    logic [NBITS-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
`ifdef COMB_WIRES_DESER_LSB_FIRST_EN
            data_d = {bit_in, data_q[NBITS-1:1]};
`else
            data_d = {data_q[NBITS-2:0], bit_in};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/comb_wires_100b_deser.sv
// Serial bit stream to NBITS-wide parallel word, valid/ready on both sides.
// Optional LSB-first assembly via COMB_WIRES_DESER_LSB_FIRST_EN (handled in the shift register).
module comb_wires_100b_deser
    import comb_wires_deser_pkg::*;
#(
    parameter int NBITS = DESER_NBITS
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_val,
    output logic                                 in_rdy,
    input  logic                                 in_bit,
    output logic                                 out_val,
    input  logic                                 out_rdy,
    output logic [NBITS-1:0]                     out,
    output logic [deser_count_width(NBITS)-1:0]  count
);

    localparam int CW = deser_count_width(NBITS);

    if (NBITS < 2 || NBITS > 128) begin : g_bad_nbits
        $error("comb_wires_100b_deser: NBITS out of range 2..128");
    end

    deser_state_e    state_q;
    deser_state_e    state_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            bit_xfer;
    logic            word_xfer;

    // In FULL the serial side may only advance while the word drains, so a
    // new first bit can land in the same cycle the old word leaves.
    always_comb begin
        in_rdy    = (state_q == COLLECT) ? 1'b1 : out_rdy;
        out_val   = (state_q == FULL);
        bit_xfer  = in_val & in_rdy;
        word_xfer = out_val & out_rdy;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            COLLECT: begin
                if (bit_xfer) begin
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(NBITS - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (word_xfer) begin
                    state_d = COLLECT;
                    count_d = bit_xfer ? CW'(1) : CW'(0);
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= COLLECT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    comb_wires_deser_shreg #(
        .NBITS (NBITS)
    ) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (bit_xfer),
        .bit_in   (in_bit),
        .data     (out)
    );

endmodule
